mac_frame_generator: RTL and testbench

- Transmit-side counterpart of the team's MAC frame checker.
- On request, emits one complete Ethernet frame on a 64-bit data / 8-bit control MII-style lane interface, then returns to idle. Frame order: start code, preamble, SFD, DA, SA, length, incrementing-pattern payload, FCS, terminate code, idle fill.
- Drives the checker's input in loopback benches and serves as the stimulus source for the PCS/encoder path.

---
 rtl/mac_frame_pkg.sv | 34 +++
 rtl/mac_crc64_lanes.sv | 23 ++
 rtl/mac_frame_generator.sv | 206 ++++++++++++++++++++
 tb/tb_mac_frame_generator.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_frame_pkg.sv
// Shared definitions for the MAC frame generator/checker pair: line codes,
// header field offsets, payload limits, FSM states and the byte-wise CRC step.
package mac_frame_pkg;

  localparam logic [7:0]  CODE_IDLE     = 8'h07;
  localparam logic [7:0]  CODE_START    = 8'hFB;
  localparam logic [7:0]  CODE_TERM     = 8'hFD;
  localparam logic [7:0]  CODE_PREAMBLE = 8'h55;
  localparam logic [7:0]  CODE_SFD      = 8'hD5;
  localparam logic [47:0] DEF_DST_ADDR  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] DEF_SRC_ADDR  = 48'h1234_5678_9ABC;

  localparam int OFF_DA      = 8;
  localparam int OFF_SA      = 14;
  localparam int OFF_LEN     = 20;
  localparam int OFF_PAYLOAD = 22;

  localparam int MIN_PAYLOAD = 46;
  localparam int MAX_PAYLOAD = 1500;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {IDLE, XMIT, IPG} state_e;

  // Team CRC variant: a full 32-step shift per byte, result re-inverted each byte.
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {d, 24'h0};
    for (int i = 0; i < 32; i++) x = x[31] ? ((x << 1) ^ CRC_POLY) : (x << 1);
    return ~x;
  endfunction

endpackage

// File: rtl/mac_crc64_lanes.sv
// Combinational CRC advance over the enabled byte lanes of one block,
// lane 0 first.
module mac_crc64_lanes
  import mac_frame_pkg::*;
#(
  parameter int NUM_LANES = 8
) (
  input  logic [31:0]                crc_i,
  input  logic [NUM_LANES-1:0][7:0]  data_i,
  input  logic [NUM_LANES-1:0]       en_i,
  output logic [31:0]                crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int n = 0; n < NUM_LANES; n++)
      if (en_i[n]) c = crc32_byte_update(c, data_i[n]);
    crc_o = c;
  end

endmodule

// File: rtl/mac_frame_generator.sv
// Emits one Ethernet frame per accepted request on a 64-bit/8-lane MII-style
// interface, followed by a single idle block of inter-packet gap.
module mac_frame_generator
  import mac_frame_pkg::*;
#(
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = 8,
  parameter logic [7:0]  IDLE_CODE     = CODE_IDLE,
  parameter logic [7:0]  START_CODE    = CODE_START,
  parameter logic [7:0]  TERM_CODE     = CODE_TERM,
  parameter logic [7:0]  PREAMBLE_CODE = CODE_PREAMBLE,
  parameter logic [7:0]  SFD_CODE      = CODE_SFD,
  parameter logic [47:0] DST_ADDR_CODE = DEF_DST_ADDR,
  parameter logic [47:0] SRC_ADDR_CODE = DEF_SRC_ADDR
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [10:0]           i_payload_len,
  input  logic [7:0]            i_payload_seed,
  input  logic                  i_inject_fcs_err,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int NL = CTRL_WIDTH;

  state_e                state_q, state_d;
  logic [7:0]            blk_q, blk_d;
  logic [10:0]           len_q, len_d;
  logic [7:0]            seed_q, seed_d;
  logic                  inj_q, inj_d;
  logic [31:0]           crc_q, crc_d;
  logic [NL-1:0][7:0]    data_q, data_d;
  logic [NL-1:0]         ctrl_q, ctrl_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                  in_idle, req_ok;
  logic [10:0]           cur_len;
  logic [7:0]            cur_seed, cur_blk;
  logic                  cur_inj;
  logic [31:0]           crc_in, crc_next, fcs_val;
  logic [NL-1:0][7:0]    raw, lane_data;
  logic [NL-1:0]         lane_ctl, crc_en, term_lane;

  // In IDLE the block being built is block 0 of the incoming request.
  assign in_idle  = (state_q == IDLE);
  assign req_ok   = (i_payload_len >= 11'(MIN_PAYLOAD)) && (i_payload_len <= 11'(MAX_PAYLOAD));
  assign cur_len  = in_idle ? i_payload_len    : len_q;
  assign cur_seed = in_idle ? i_payload_seed   : seed_q;
  assign cur_inj  = in_idle ? i_inject_fcs_err : inj_q;
  assign cur_blk  = in_idle ? 8'd0             : blk_q;
  assign crc_in   = in_idle ? CRC_INIT         : crc_q;
  assign fcs_val  = crc_next ^ {31'b0, cur_inj};

  generate
    for (genvar n = 0; n < NL; n++) begin : g_lane
      logic [11:0] b, len12;
      logic [7:0]  l_raw;
      logic        l_ctl, l_en, l_fsel, l_term;
      logic [1:0]  l_fidx;

      assign b     = {1'b0, cur_blk, 3'(n)};
      assign len12 = {1'b0, cur_len};

      always_comb begin
        l_raw  = IDLE_CODE;
        l_ctl  = 1'b1;
        l_fsel = 1'b0;
        l_fidx = 2'd0;
        l_term = 1'b0;
        l_en   = (b >= 12'(OFF_DA)) && (b < len12 + 12'(OFF_PAYLOAD));
        if (b == 12'd0) begin
          l_raw = START_CODE;
        end else if (b < 12'(OFF_DA)) begin
          l_ctl = 1'b0;
          l_raw = (b == 12'(OFF_DA - 1)) ? SFD_CODE : PREAMBLE_CODE;
        end else if (b < 12'(OFF_SA)) begin
          l_ctl = 1'b0;
          l_raw = 8'(DST_ADDR_CODE >> {b - 12'(OFF_DA), 3'b0});
        end else if (b < 12'(OFF_LEN)) begin
          l_ctl = 1'b0;
          l_raw = 8'(SRC_ADDR_CODE >> {b - 12'(OFF_SA), 3'b0});
        end else if (b == 12'(OFF_LEN)) begin
          l_ctl = 1'b0;
          l_raw = cur_len[7:0];
        end else if (b == 12'(OFF_LEN + 1)) begin
          l_ctl = 1'b0;
          l_raw = {5'b0, cur_len[10:8]};
        end else if (b < len12 + 12'(OFF_PAYLOAD)) begin
          l_ctl = 1'b0;
          l_raw = cur_seed + 8'(b - 12'(OFF_PAYLOAD));
        end else if (b < len12 + 12'(OFF_PAYLOAD + 4)) begin
          l_ctl  = 1'b0;
          l_raw  = 8'h00;
          l_fsel = 1'b1;
          l_fidx = 2'(b - len12 - 12'(OFF_PAYLOAD));
        end else if (b == len12 + 12'(OFF_PAYLOAD + 4)) begin
          l_raw  = TERM_CODE;
          l_term = 1'b1;
        end
      end

      assign raw[n]       = l_raw;
      assign crc_en[n]    = l_en;
      assign lane_ctl[n]  = l_ctl;
      assign term_lane[n] = l_term;
      // FCS lanes take the CRC already advanced over this block's data lanes.
      assign lane_data[n] = l_fsel ? 8'(fcs_val >> {l_fidx, 3'b0}) : l_raw;
    end
  endgenerate

  mac_crc64_lanes #(.NUM_LANES(NL)) u_crc (
    .crc_i  (crc_in),
    .data_i (raw),
    .en_i   (crc_en),
    .crc_o  (crc_next)
  );

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    len_d   = len_q;
    seed_d  = seed_q;
    inj_d   = inj_q;
    crc_d   = crc_q;
    data_d  = {NL{IDLE_CODE}};
    ctrl_d  = '1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (req_ok) begin
            len_d   = i_payload_len;
            seed_d  = i_payload_seed;
            inj_d   = i_inject_fcs_err;
            data_d  = lane_data;
            ctrl_d  = lane_ctl;
            busy_d  = 1'b1;
            blk_d   = 8'd1;
            crc_d   = crc_next;
            state_d = XMIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      XMIT: begin
        data_d = lane_data;
        ctrl_d = lane_ctl;
        busy_d = 1'b1;
        blk_d  = blk_q + 8'd1;
        crc_d  = crc_next;
        if (|term_lane) begin
          done_d  = 1'b1;
          state_d = IPG;
        end
      end
      IPG: begin
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      blk_q   <= 8'd0;
      len_q   <= 11'd0;
      seed_q  <= 8'd0;
      inj_q   <= 1'b0;
      crc_q   <= CRC_INIT;
      data_q  <= {NL{IDLE_CODE}};
      ctrl_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      inj_q   <= inj_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_tx_data = data_q;
  assign o_tx_ctrl = ctrl_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_mac_frame_generator.sv
// Scoreboard bench: a reference frame builder queues expected blocks per
// request, a negedge monitor pops and compares them as frames appear.
module tb_mac_frame_generator;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    bit          last;
  } blk_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [10:0] i_payload_len = 11'd0;
  logic [7:0]  i_payload_seed = 8'd0;
  logic        i_inject_fcs_err = 1'b0;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        o_busy, o_done, o_err;

  int   n_chk = 0;
  int   n_fail = 0;
  blk_t exp_q[$];
  bit   mon_en = 1'b1;
  bit   in_frame = 1'b0;

  localparam logic [63:0] IDLE_BLK = 64'h0707070707070707;

  mac_frame_generator dut (
    .clk              (clk),
    .i_rst            (i_rst),
    .i_start          (i_start),
    .i_payload_len    (i_payload_len),
    .i_payload_seed   (i_payload_seed),
    .i_inject_fcs_err (i_inject_fcs_err),
    .o_tx_data        (o_tx_data),
    .o_tx_ctrl        (o_tx_ctrl),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference frame builder straight from the byte map.
  task automatic push_frame(input int L, input logic [7:0] seed, input bit inj);
    logic [7:0]  fr [0:1599];
    bit          ct [0:1599];
    logic [47:0] da, sa;
    logic [10:0] lenv;
    logic [31:0] c, x;
    int          F, nb;
    blk_t        e;
    da = 48'hFFFF_FFFF_FFFF;
    sa = 48'h1234_5678_9ABC;
    lenv = 11'(L);
    F = L + 27;
    nb = (F + 7) / 8;
    for (int i = 0; i < nb * 8; i++) begin fr[i] = 8'h07; ct[i] = 1'b1; end
    fr[0] = 8'hFB;
    for (int i = 1; i < 7; i++) begin fr[i] = 8'h55; ct[i] = 1'b0; end
    fr[7] = 8'hD5; ct[7] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fr[8 + i] = da[8*i +: 8];  ct[8 + i] = 1'b0;
      fr[14 + i] = sa[8*i +: 8]; ct[14 + i] = 1'b0;
    end
    fr[20] = lenv[7:0];          ct[20] = 1'b0;
    fr[21] = {5'b0, lenv[10:8]}; ct[21] = 1'b0;
    for (int k = 0; k < L; k++) begin fr[22 + k] = seed + 8'(k); ct[22 + k] = 1'b0; end
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < L + 22; i++) begin
      x = c ^ {fr[i], 24'h0};
      for (int s = 0; s < 32; s++) x = x[31] ? ((x << 1) ^ 32'h04C1_1DB7) : (x << 1);
      c = ~x;
    end
    if (inj) c[0] = ~c[0];
    for (int i = 0; i < 4; i++) begin fr[L + 22 + i] = c[8*i +: 8]; ct[L + 22 + i] = 1'b0; end
    fr[L + 26] = 8'hFD;
    for (int j = 0; j < nb; j++) begin
      for (int n = 0; n < 8; n++) begin
        e.d[8*n +: 8] = fr[8*j + n];
        e.c[n] = ct[8*j + n];
      end
      e.last = (j == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    blk_t e;
    if (mon_en) begin
      if (!in_frame && o_tx_ctrl[0] && o_tx_data[7:0] == 8'hFB) begin
        if (exp_q.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
        else in_frame = 1'b1;
      end
      if (in_frame) begin
        if (exp_q.size() == 0) begin
          chk("frame_overrun", 64'd1, 64'd0);
          in_frame = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk("blk_data", o_tx_data, e.d);
          chk("blk_ctrl", 64'(o_tx_ctrl), 64'(e.c));
          chk("blk_done", 64'(o_done), 64'(e.last));
          if (e.last) in_frame = 1'b0;
        end
      end
    end
  end

  // Returns with block 0 visible on the outputs.
  task automatic send(input int L, input logic [7:0] seed, input bit inj, input bit model);
    if (model) push_frame(L, seed, inj);
    @(posedge clk); #1;
    i_start = 1'b1; i_payload_len = 11'(L); i_payload_seed = seed; i_inject_fcs_err = inj;
    @(posedge clk); #1;
    i_start = 1'b0; i_payload_len = 11'd999; i_payload_seed = ~seed; i_inject_fcs_err = ~inj;
  endtask

  task automatic wait_done(output int nblk, output logic [7:0] ctl);
    nblk = 0; ctl = 8'h00;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (o_done) begin nblk = cyc; ctl = o_tx_ctrl; break; end
    end
    if (nblk == 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  task automatic bad_req(input int L);
    int errs = 0, busies = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_payload_len = 11'(L);
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("err_pulse", 64'(o_err), 64'd1);
    chk("err_data", o_tx_data, IDLE_BLK);
    chk("err_ctrl", 64'(o_tx_ctrl), 64'hFF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      errs += int'(o_err);
      busies += int'(o_busy);
    end
    chk("err_once", 64'(errs), 64'd0);
    chk("err_busy", 64'(busies), 64'd0);
  endtask

  initial begin
    int nblk, cnt_d, cnt_b;
    logic [7:0] ctl;
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nblk, cnt_d, cnt_b;
    logic [7:0] ctl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", o_tx_data, IDLE_BLK);
    chk("rst_ctrl", 64'(o_tx_ctrl), 64'hFF);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    @(posedge clk); #1; i_rst = 1'b0;

    // Minimum frame, fully pinned down by constants.
    send(46, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("l46_blk0_data", o_tx_data, 64'hD5555555555555FB);
    chk("l46_blk0_ctrl", 64'(o_tx_ctrl), 64'h01);
    chk("l46_busy", 64'(o_busy), 64'd1);
    wait_done(nblk, ctl);
    nblk++;
    chk("l46_nblk", 64'(nblk), 64'd10);
    chk("l46_term_ctrl", 64'(ctl), 64'hFF);
    @(negedge clk);
    chk("l46_ipg_data", o_tx_data, IDLE_BLK);
    chk("l46_ipg_busy", 64'(o_busy), 64'd1);
    @(negedge clk);
    chk("l46_post_busy", 64'(o_busy), 64'd0);

    send(47, 8'($urandom_range(255)), 1'b0, 1'b1);
    wait_done(nblk, ctl);
    chk("l47_nblk", 64'(nblk), 64'd10);
    chk("l47_term_ctrl", 64'(ctl), 64'hFE);
    wait_idle();

    send(1500, 8'($urandom_range(255)), 1'b0, 1'b1);
    wait_done(nblk, ctl);
    chk("l1500_nblk", 64'(nblk), 64'd191);
    chk("l1500_term_ctrl", 64'(ctl), 64'hC0);
    wait_idle();

    send(100, 8'($urandom_range(255)), 1'b0, 1'b1); wait_done(nblk, ctl); wait_idle();
    send(46, 8'($urandom_range(255)), 1'b1, 1'b1);  wait_done(nblk, ctl); wait_idle();
    send(100, 8'($urandom_range(255)), 1'b1, 1'b1); wait_done(nblk, ctl); wait_idle();
    send(1500, 8'($urandom_range(255)), 1'b1, 1'b1); wait_done(nblk, ctl); wait_idle();

    bad_req(45);
    bad_req(1501);
    bad_req(0);

    // Start held high: back-to-back frames with a single idle block between.
    push_frame(50, 8'h03, 1'b0);
    push_frame(50, 8'h03, 1'b0);
    @(posedge clk); #1;
    i_start = 1'b1; i_payload_len = 11'd50; i_payload_seed = 8'h03; i_inject_fcs_err = 1'b0;
    @(posedge clk); #1;
    wait_done(nblk, ctl);
    @(negedge clk);
    chk("held_gap_data", o_tx_data, IDLE_BLK);
    chk("held_gap_busy", 64'(o_busy), 64'd1);
    @(negedge clk);
    chk("held_restart", 64'({o_tx_ctrl[0], o_tx_data[7:0]}), 64'h1FB);
    i_start = 1'b0;
    wait_done(nblk, ctl);
    chk("held_nblk", 64'(nblk), 64'd9);
    wait_idle();

    // Mid-frame request pulse must be ignored.
    send(120, 8'h5A, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1; i_start = 1'b1; i_payload_len = 11'd60; i_payload_seed = 8'h11;
    @(posedge clk); #1; i_start = 1'b0;
    wait_done(nblk, ctl);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("midpulse_no_frame", 64'(o_busy), 64'd0);

    // Reset during block 5 abandons the frame without a terminate.
    mon_en = 1'b0;
    send(200, 8'h77, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1; i_rst = 1'b1;
    @(posedge clk); #1; i_rst = 1'b0;
    @(negedge clk);
    chk("abort_data", o_tx_data, IDLE_BLK);
    chk("abort_ctrl", 64'(o_tx_ctrl), 64'hFF);
    chk("abort_busy", 64'(o_busy), 64'd0);
    cnt_d = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt_d += int'(o_done);
      cnt_b += int'(o_busy);
    end
    chk("abort_no_done", 64'(cnt_d), 64'd0);
    chk("abort_no_busy", 64'(cnt_b), 64'd0);
    mon_en = 1'b1;
    send(64, 8'hC3, 1'b0, 1'b1);
    wait_done(nblk, ctl);
    chk("post_abort_nblk", 64'(nblk), 64'd12);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
